cpu_param: RTL

- Parametrised successor of the 4-bit X/Y/Z teaching CPU.
- Multi-cycle CPU with FSM control: program counter, external synchronous program ROM, X/Y/Z registers, parametrised ALU, zero/carry flags, conditional branching, halt.
- Top level of the state-machine CPU; drives the ROM address and exposes registers, load strobes and state for the debug/LED wrapper.

---
 rtl/cpu_param_pkg.sv | 35 +++
 rtl/ula_param.sv | 47 ++++
 rtl/cpu_param.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_param_pkg.sv
// Shared definitions for the parametrised X/Y/Z teaching CPU: opcode field
// width, opcode values, FSM state encoding and an opcode classifier.
package cpu_param_pkg;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_LDX  = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'd7;
  localparam logic [OPCODE_W-1:0] OP_MOVZ = 4'd8;
  localparam logic [OPCODE_W-1:0] OP_CLRY = 4'd9;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'd10;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 4'd11;
  localparam logic [OPCODE_W-1:0] OP_JC   = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcodes whose ALU result is written to Y (and which update the flags).
  function automatic logic writes_y(input logic [OPCODE_W-1:0] op);
    return (op >= OP_ADD && op <= OP_NOT) || (op == OP_CLRY);
  endfunction

endpackage

// File: rtl/ula_param.sv
// Combinational ALU: Y-side result of the current opcode, carry/borrow and
// zero detect. Opcodes that do not produce a Y result pass Y through.
module ula_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]   y,
  input  logic [OPCODE_W-1:0] op,
  output logic [DATA_W-1:0]   result,
  output logic                carry,
  output logic                zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, y} + {1'b0, x};
  // The extra top bit of the difference is the borrow, i.e. set iff x > y.
  assign diff = {1'b0, y} - {1'b0, x};

  // Select the result and carry for the opcode.
  always_comb begin
    result = y;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = y & x;
      OP_OR:   result = y | x;
      OP_XOR:  result = y ^ x;
      OP_NOT:  result = ~x;
      OP_CLRY: result = '0;
      default: result = y;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_param.sv
// Multi-cycle X/Y/Z CPU: FETCH / DECODE / EXEC sequencing over an external
// synchronous ROM, with halt and restart. start is a level sampled only in
// IDLE and HALT; there is no other handshake, rom_data is simply consumed
// one cycle after rom_addr is presented.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 4 + DATA_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [DATA_W-1:0]  reg_x,
  output logic [DATA_W-1:0]  reg_y,
  output logic [DATA_W-1:0]  reg_z,
  output logic [DATA_W-1:0]  alu_out,
  output logic               flag_z,
  output logic               flag_c,
  output logic               ld_x,
  output logic               ld_y,
  output logic               ld_z,
  output logic [2:0]         state,
  output logic               halted
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   x_q;
  logic [DATA_W-1:0]   y_q;
  logic [DATA_W-1:0]   z_q;
  logic                fz_q;
  logic                fc_q;

  logic [OPCODE_W-1:0] opcode;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   target;
  logic                take_branch;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic                alu_zero;

  assign opcode = ir_q[INSTR_W-1 -: OPCODE_W];
  assign imm    = ir_q[DATA_W-1:0];

  // The branch target is the immediate resized to the PC width.
  generate
    if (ADDR_W > DATA_W) begin : g_tgt_ext
      assign target = {{(ADDR_W-DATA_W){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign target = imm[ADDR_W-1:0];
    end
  endgenerate

  ula_param #(.DATA_W(DATA_W)) u_ula (
    .x      (x_q),
    .y      (y_q),
    .op     (opcode),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: every instruction spends one cycle in each of FETCH, DECODE, EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:   if (start) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and IR: load strobes, branch decision, halted.
  always_comb begin
    ld_x        = 1'b0;
    ld_y        = 1'b0;
    ld_z        = 1'b0;
    take_branch = 1'b0;
    halted      = (state_q == ST_HALT);
    if (state_q == ST_EXEC) begin
      ld_x = (opcode == OP_LDX);
      ld_y = writes_y(opcode);
      ld_z = (opcode == OP_MOVZ);
      // Conditions read the flags as they stood before this EXEC edge.
      take_branch = (opcode == OP_JMP) ||
                    (opcode == OP_JZ && fz_q) ||
                    (opcode == OP_JC && fc_q);
    end
  end

  // Datapath: PC, IR, X/Y/Z and flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
      ir_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      fz_q <= 1'b0;
      fc_q <= 1'b0;
    end else begin
      case (state_q)
        ST_DECODE: ir_q <= rom_data;
        ST_EXEC: begin
          pc_q <= take_branch ? target : pc_q + ADDR_W'(1);
          if (ld_x) x_q <= imm;
          if (ld_y) begin
            y_q  <= alu_result;
            fz_q <= alu_zero;
            fc_q <= alu_carry;
          end
          if (ld_z) z_q <= y_q;
        end
        ST_HALT: if (start) pc_q <= '0;
        default: ;
      endcase
    end
  end

  assign rom_addr = pc_q;
  assign reg_x    = x_q;
  assign reg_y    = y_q;
  assign reg_z    = z_q;
  assign alu_out  = alu_result;
  assign flag_z   = fz_q;
  assign flag_c   = fc_q;
  assign state    = state_q;

endmodule
